// File: rtl/alu_seq_pkg.sv
// Package for the bit-serial ALU sequencer.
// Holds the MIPS funct codes the sequencer understands, the select codes of the
// 1-bit ALU slice, the controller state enum and the funct decoder.
package alu_seq_pkg;

    // MIPS R-type funct codes
    localparam logic [5:0] FUNCT_AND = 6'd36;
    localparam logic [5:0] FUNCT_OR  = 6'd37;
    localparam logic [5:0] FUNCT_ADD = 6'd32;
    localparam logic [5:0] FUNCT_SUB = 6'd34;
    localparam logic [5:0] FUNCT_SLT = 6'd42;

    // Output select of the 1-bit slice
    localparam logic [1:0] SEL_AND  = 2'd0;
    localparam logic [1:0] SEL_OR   = 2'd1;
    localparam logic [1:0] SEL_SUM  = 2'd2;
    localparam logic [1:0] SEL_LESS = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] sel;
        logic       inv;  // also the initial carry-in
    } slice_ctrl_t;

    // Unsupported codes fall back to AND with no inversion; the result is
    // discarded later, so the choice only has to be harmless.
    function automatic slice_ctrl_t decode_funct(input logic [5:0] funct);
        slice_ctrl_t ctrl;
        ctrl.sel = SEL_AND;
        ctrl.inv = 1'b0;
        case (funct)
            FUNCT_AND: ctrl.sel = SEL_AND;
            FUNCT_OR:  ctrl.sel = SEL_OR;
            FUNCT_ADD: ctrl.sel = SEL_SUM;
            FUNCT_SUB: begin
                ctrl.sel = SEL_SUM;
                ctrl.inv = 1'b1;
            end
            FUNCT_SLT: begin
                ctrl.sel = SEL_SUM;
                ctrl.inv = 1'b1;
            end
            default: begin
                ctrl.sel = SEL_AND;
                ctrl.inv = 1'b0;
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_serial_sequencer_alu_bit.sv
// One-bit ALU slice: full adder plus a 4:1 output select.
// Ports:
//   a_i, b_i     operand bits
//   invert_i     inverts b_i before it reaches the logic and the adder
//   cin_i        carry in
//   less_i       value passed through when op_i selects LESS
//   op_i         0=AND, 1=OR, 2=sum, 3=less
//   result_o     selected output bit
//   cout_o       full-adder carry out
//   set_o        raw sum bit (sign bit of the difference when used at the MSB)
module alu_serial_sequencer_alu_bit
    import alu_seq_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       invert_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       result_o,
    output logic       cout_o,
    output logic       set_o
);

    logic b_eff;
    logic sum;

    always_comb begin
        b_eff  = b_i ^ invert_i;
        sum    = a_i ^ b_eff ^ cin_i;
        cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
        set_o  = sum;
        case (op_i)
            SEL_AND:  result_o = a_i & b_eff;
            SEL_OR:   result_o = a_i | b_eff;
            SEL_SUM:  result_o = sum;
            SEL_LESS: result_o = less_i;
            default:  result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU controller: time-shares a single 1-bit ALU slice across a
// WIDTH-bit AND/OR/ADD/SUB/SLT, one bit per clock, LSB first.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     request, sampled only in IDLE
//   dataA/B   operands, latched when start is accepted
//   signal    MIPS funct code
//   dataOut   result, written on entry to DONE and held afterwards
//   carryOut  carry out of the MSB for ADD/SUB, 0 otherwise
//   busy      high from the cycle after accept through the done cycle
//   done      one-cycle pulse, dataOut/carryOut valid from this cycle
module alu_serial_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             carryOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [5:0]       funct_q, funct_d;
    logic [1:0]       sel_q, sel_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             cout_q, cout_d;

    slice_ctrl_t      ctrl;

    logic       sl_a, sl_b, sl_inv, sl_cin;
    logic [1:0] sl_op;
    logic       sl_res, sl_cout, sl_set;

    alu_serial_sequencer_alu_bit u_slice (
        .a_i      (sl_a),
        .b_i      (sl_b),
        .invert_i (sl_inv),
        .cin_i    (sl_cin),
        .less_i   (1'b0),
        .op_i     (sl_op),
        .result_o (sl_res),
        .cout_o   (sl_cout),
        .set_o    (sl_set)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        funct_d = funct_q;
        sel_d   = sel_q;
        inv_d   = inv_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
        sl_a    = 1'b0;
        sl_b    = 1'b0;
        sl_inv  = 1'b0;
        sl_cin  = 1'b0;
        sl_op   = SEL_AND;
        busy    = 1'b0;
        done    = 1'b0;
        ctrl    = decode_funct(signal);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dataA;
                    b_d     = dataB;
                    funct_d = signal;
                    sel_d   = ctrl.sel;
                    inv_d   = ctrl.inv;
                    carry_d = ctrl.inv;  // +1 of two's-complement negate
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                busy   = 1'b1;
                sl_a   = a_q[0];
                sl_b   = b_q[0];
                sl_inv = inv_q;
                sl_cin = carry_q;
                sl_op  = sel_q;
                // Operands shift down so bit 0 is always the current bit; the
                // result shifts in from the top so after WIDTH steps it is aligned.
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {sl_res, res_q[WIDTH-1:1]};
                carry_d = sl_cout;
                if (cnt_q == LastBit) begin
                    state_d = DONE;
                    dout_d  = '0;
                    cout_d  = 1'b0;
                    case (funct_q)
                        FUNCT_AND, FUNCT_OR: dout_d = res_d;
                        FUNCT_ADD, FUNCT_SUB: begin
                            dout_d = res_d;
                            cout_d = sl_cout;
                        end
                        // Sign of the difference corrected by overflow
                        // (carry into MSB xor carry out of MSB).
                        FUNCT_SLT: dout_d[0] = sl_set ^ (carry_q ^ sl_cout);
                        default: begin
                            dout_d = '0;
                            cout_d = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            funct_q <= '0;
            sel_q   <= SEL_AND;
            inv_q   <= 1'b0;
            dout_q  <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            funct_q <= funct_d;
            sel_q   <= sel_d;
            inv_q   <= inv_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
        end
    end

    assign dataOut  = dout_q;
    assign carryOut = cout_q;

endmodule
